// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler for the 32x32 register file: round-robin arbitration of
// NREQ result producers onto one registered write port, plus a busy scoreboard.
module rf_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      wb_valid,
  output logic [NREQ-1:0]      wb_ready,
  input  logic [5*NREQ-1:0]    wb_rd,
  input  logic [XLEN*NREQ-1:0] wb_data,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  input  logic [4:0]           issue_rd,
  output logic                 issue_stall,
  input  logic                 flush,
  output logic [31:0]          busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: requester i transfers in a cycle where wb_valid[i] && wb_ready[i];
  // it must hold wb_valid/wb_rd/wb_data stable until then. wb_ready is one-hot or zero.

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            hit_rs1, hit_rs2, hit_rd;
  logic            issue_set;
  int              idx;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!xfer && wb_valid[idx]) begin
        xfer       = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
      end
    end
  end

  assign wb_ready = grant;
  assign sel_rd   = wb_rd[5*gnt_idx +: 5];
  assign sel_data = wb_data[XLEN*gnt_idx +: XLEN];

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // x0 results complete the handshake but never reach the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_we_d    = (sel_rd != 5'd0);
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  assign hit_rs1     = (issue_rs1 != 5'd0) && busy_q[issue_rs1];
  assign hit_rs2     = (issue_rs2 != 5'd0) && busy_q[issue_rs2];
  assign hit_rd      = (issue_rd  != 5'd0) && busy_q[issue_rd];
  assign issue_stall = issue_valid && (hit_rs1 || hit_rs2 || hit_rd);
  assign issue_set   = issue_valid && !issue_stall && (issue_rd != 5'd0);

  // Priority low to high: clear on write, set on issue, flush.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration order, write latency,
// scoreboard hazards, flush and asynchronous reset.
module tb_rf_wb_scheduler;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ-1:0]      wb_ready;
  logic [5*NREQ-1:0]    wb_rd;
  logic [XLEN*NREQ-1:0] wb_data;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 issue_valid;
  logic [4:0]           issue_rs1, issue_rs2, issue_rd;
  logic                 issue_stall;
  logic                 flush;
  logic [31:0]          busy;

  int errors = 0;
  int checks = 0;

  rf_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_stall(issue_stall),
    .flush(flush), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid    = '0;
    issue_valid = 1'b0;
    issue_rs1   = 5'd0;
    issue_rs2   = 5'd0;
    issue_rd    = 5'd0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb_rd   = '0;
    wb_data = '0;
    rst_n   = 1'b0;
    wb_valid = 3'b110;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (wb_ready !== 3'b010) begin errors++; $display("FAIL reset_ready got=%b exp=010", wb_ready); end
    step();
    step();
    wb_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    wb_rd[4:0]    = 5'd5;
    wb_data[31:0] = 32'hDEADBEEF;
    wb_valid      = 3'b001;
    #1;
    checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", wb_ready); end
    step();
    wb_valid = '0;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got=%b exp=0", rf_we); end
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_rd   [3];
    logic [31:0] exp_data [3];
    int          g;
    exp_rd   = '{5'd1, 5'd2, 5'd3};
    exp_data = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222};
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NREQ; i++) begin
      wb_rd[5*i +: 5]      = exp_rd[i];
      wb_data[XLEN*i +: XLEN] = exp_data[i];
    end
    wb_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      #1;
      checks++; if (wb_ready !== (3'b001 << g)) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp_idx=%0d", c, wb_ready, g); end
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_rd[g] || rf_wdata !== exp_data[g]) begin
        errors++; $display("FAIL rr_write cyc=%0d got we=%b addr=%0d data=%h exp addr=%0d data=%h", c, rf_we, rf_waddr, rf_wdata, exp_rd[g], exp_data[g]);
      end
    end
    wb_valid = '0;
    step();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rr_idle_we got=%b exp=0", rf_we); end
  endtask

  // ptr = 0 on entry
  task automatic test_hazard_timing();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL hz_first_stall got=%b exp=0", issue_stall); end
    step();
    issue_rd = 5'd0; issue_rs1 = 5'd7;
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL hz_busy_set got=%h exp=00000080", busy); end
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL hz_raw_stall got=%b exp=1", issue_stall); end
    step();
    wb_rd[9:5] = 5'd7; wb_data[63:32] = 32'h0000_0077; wb_valid = 3'b010;
    #1;
    checks++; if (wb_ready !== 3'b010 || issue_stall !== 1'b1) begin errors++; $display("FAIL hz_T got ready=%b stall=%b exp 010/1", wb_ready, issue_stall); end
    step();
    wb_valid = '0;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || issue_stall !== 1'b1) begin errors++; $display("FAIL hz_T1 got we=%b addr=%0d stall=%b exp 1/7/1", rf_we, rf_waddr, issue_stall); end
    step();
    checks++; if (issue_stall !== 1'b0 || busy !== 32'd0) begin errors++; $display("FAIL hz_T2 got stall=%b busy=%h exp 0/0", issue_stall, busy); end
    idle_inputs();
  endtask

  // ptr = 2 on entry
  task automatic test_x0_waw();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_issue_busy got=%h exp=0", busy); end
    issue_rd = 5'd3;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL waw_first got=%b exp=0", issue_stall); end
    step();
    checks++; if (busy !== 32'h0000_0008 || issue_stall !== 1'b1) begin errors++; $display("FAIL waw_second got busy=%h stall=%b exp 00000008/1", busy, issue_stall); end
    step();
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL waw_hold got=%h exp=00000008", busy); end
    wb_rd[14:10] = 5'd0; wb_data[95:64] = 32'h0000_1234; wb_valid = 3'b100;
    #1;
    checks++; if (wb_ready !== 3'b100) begin errors++; $display("FAIL x0_wb_ready got=%b exp=100", wb_ready); end
    step();
    wb_rd[4:0] = 5'd3; wb_data[31:0] = 32'h3333_3333; wb_valid = 3'b001;
    checks++; if (rf_we !== 1'b0 || busy !== 32'h0000_0008) begin errors++; $display("FAIL x0_wb_we got we=%b busy=%h exp 0/00000008", rf_we, busy); end
    step();
    wb_valid = '0;
    step();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL waw_clear got=%h exp=0", busy); end
    idle_inputs();
  endtask

  // ptr = 1 on entry; x9 write-back has no scoreboard entry
  task automatic test_set_clear_collision();
    wb_rd[4:0] = 5'd9; wb_data[31:0] = 32'h9999_9999; wb_valid = 3'b001;
    step();
    wb_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || issue_stall !== 1'b0) begin errors++; $display("FAIL coll_setup got we=%b addr=%0d stall=%b exp 1/9/0", rf_we, rf_waddr, issue_stall); end
    step();
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL coll_busy got=%h exp=00000200", busy); end
  endtask

  // ptr = 1 on entry, busy = x9
  task automatic test_flush_and_reset();
    logic [4:0] rds [3];
    rds = '{5'd8, 5'd10, 5'd11};
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = rds[i];
      step();
    end
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0F00) begin errors++; $display("FAIL flush_setup got=%h exp=00000f00", busy); end
    flush = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd12;
    wb_rd[9:5] = 5'd8; wb_data[63:32] = 32'h0000_00F1; wb_valid = 3'b010;
    #1;
    checks++; if (wb_ready !== 3'b010) begin errors++; $display("FAIL flush_ready got=%b exp=010", wb_ready); end
    step();
    idle_inputs();
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL flush_busy got=%h exp=0", busy); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_00F1) begin errors++; $display("FAIL flush_write got we=%b addr=%0d data=%h exp 1/8/000000f1", rf_we, rf_waddr, rf_wdata); end
    // ptr = 2 now
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    wb_rd[14:10] = 5'd4; wb_data[95:64] = 32'h0000_00AA; wb_valid = 3'b100;
    step();
    wb_valid = '0;
    checks++; if (rf_we !== 1'b1 || busy !== 32'h0000_0010) begin errors++; $display("FAIL areset_setup got we=%b busy=%h exp 1/00000010", rf_we, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || busy !== 32'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL areset got we=%b busy=%h addr=%0d data=%h exp all 0", rf_we, busy, rf_waddr, rf_wdata);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hazard_timing();
    test_x0_waw();
    test_set_clear_collision();
    test_flush_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
